// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared GPR constants and instruction field helpers
package reg_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam int NUM_GPR = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA = 5'd31;
  function automatic logic [REG_W-1:0] rs_of(input logic [31:0] instr);
    return instr[25:21];
  endfunction
  function automatic logic [REG_W-1:0] rt_of(input logic [31:0] instr);
    return instr[20:16];
  endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback handshake bundle for the scoreboard
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 3
);
  logic issue_valid;
  logic issue_ready;
  logic [REG_W-1:0] issue_rs;
  logic [REG_W-1:0] issue_rt;
  logic issue_use_rs;
  logic issue_use_rt;
  logic [REG_W-1:0] issue_wreg;
  logic wb_valid;
  logic [REG_W-1:0] wb_reg;
  logic flush;
  logic [NUM_GPR-1:0] busy_mask;
  logic [CNT_W-1:0] inflight;
  logic wb_err;
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt, issue_wreg,
    output wb_valid, wb_reg, flush,
    input issue_ready, busy_mask, inflight, wb_err
  );
  modport slave (
    input issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt, issue_wreg,
    input wb_valid, wb_reg, flush,
    output issue_ready, busy_mask, inflight, wb_err
  );
endinterface

// File: rtl/reg_scoreboard_hazard_check.sv
// reg_scoreboard_hazard_check: combinational RAW/WAW/full issue gate
module reg_scoreboard_hazard_check
  import reg_scoreboard_pkg::*;
(
  input  logic [NUM_GPR-1:0] busy_i,
  input  logic [NUM_GPR-1:0] wb_clr_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic [REG_W-1:0]   wreg_i,
  input  logic               use_rs_i,
  input  logic               use_rt_i,
  input  logic               full_i,
  output logic               ready_o
);
  logic [NUM_GPR-1:0] eff;
  logic raw_rs, raw_rt, waw, full_hz;
  assign eff = busy_i & ~wb_clr_i;
  assign raw_rs = use_rs_i && rs_i != REG_ZERO && eff[rs_i];
  assign raw_rt = use_rt_i && rt_i != REG_ZERO && eff[rt_i];
  assign waw = wreg_i != REG_ZERO && eff[wreg_i];
  assign full_hz = wreg_i != REG_ZERO && full_i;
  assign ready_o = !(raw_rs || raw_rt || waw || full_hz);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: GPR in-flight write tracker; SCOREBOARD_WB_BYPASS_EN lets same-cycle writeback release hazards
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W = 3
)(
  input logic clk,
  input logic reset,
  reg_scoreboard_if.slave bus
);
  logic [NUM_GPR-1:0] busy_q, busy_d, wb_clr_vec, set_vec, hz_clr;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic wb_err_q, wb_err_d;
  logic wb_sel, wb_hit, wb_bad, full, hz_ok, ready, set;
  assign wb_sel = bus.wb_valid && bus.wb_reg != REG_ZERO;
  assign wb_hit = wb_sel && busy_q[bus.wb_reg];
  assign wb_bad = wb_sel && !busy_q[bus.wb_reg];
  assign wb_clr_vec = wb_hit ? (NUM_GPR'(1) << bus.wb_reg) : '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign hz_clr = wb_clr_vec;
  assign full = (inflight_q - CNT_W'(wb_hit)) == CNT_W'(MAX_INFLIGHT);
`else
  assign hz_clr = '0;
  assign full = inflight_q == CNT_W'(MAX_INFLIGHT);
`endif
  reg_scoreboard_hazard_check u_hz (
    .busy_i  (busy_q),
    .wb_clr_i(hz_clr),
    .rs_i    (bus.issue_rs),
    .rt_i    (bus.issue_rt),
    .wreg_i  (bus.issue_wreg),
    .use_rs_i(bus.issue_use_rs),
    .use_rt_i(bus.issue_use_rt),
    .full_i  (full),
    .ready_o (hz_ok)
  );
  assign ready = hz_ok && !bus.flush;
  assign set = bus.issue_valid && ready && bus.issue_wreg != REG_ZERO;
  assign set_vec = set ? (NUM_GPR'(1) << bus.issue_wreg) : '0;
  // next state: clear before set so a same-register issue keeps the bit busy; flush drops everything but wb_err
  always_comb begin
    busy_d = bus.flush ? '0 : ((busy_q & ~wb_clr_vec) | set_vec) & ~NUM_GPR'(1);
    inflight_d = bus.flush ? '0 : inflight_q + CNT_W'(set) - CNT_W'(wb_hit);
    wb_err_d = wb_err_q || (wb_bad && !bus.flush);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      inflight_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q <= wb_err_d;
    end
  end
  // counter must never wrap in either direction
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush) begin
      assert (!(wb_hit && !set && inflight_q == '0)) else $error("inflight underflow");
      assert (!(set && !wb_hit && inflight_q == CNT_W'(MAX_INFLIGHT))) else $error("inflight overflow");
    end
  end
  assign bus.issue_ready = ready;
  assign bus.busy_mask = busy_q;
  assign bus.inflight = inflight_q;
  assign bus.wb_err = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors for the register scoreboard
module tb_reg_scoreboard;
  logic clk = 0;
  logic reset = 1;
  int n_vec = 0;
  int n_err = 0;
  reg_scoreboard_if #(.CNT_W(3)) bus ();
  reg_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.issue_valid = 0;
    bus.issue_rs = 0;
    bus.issue_rt = 0;
    bus.issue_use_rs = 0;
    bus.issue_use_rt = 0;
    bus.issue_wreg = 0;
    bus.wb_valid = 0;
    bus.wb_reg = 0;
    bus.flush = 0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask
  task automatic iss(input logic [4:0] w);
    bus.issue_valid = 1;
    bus.issue_wreg = w;
    step();
    bus.issue_valid = 0;
    bus.issue_wreg = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_busy", bus.busy_mask, 0);
    chk("rst_infl", 32'(bus.inflight), 0);
    chk("rst_err", 32'(bus.wb_err), 0);
    chk("idle_rdy", 32'(bus.issue_ready), 1);
    iss(8);
    chk("iss8_busy", bus.busy_mask, 32'h100);
    chk("iss8_infl", 32'(bus.inflight), 1);
    bus.issue_valid = 1;
    bus.issue_use_rs = 1;
    bus.issue_rs = 8;
    #1 chk("raw_rdy", 32'(bus.issue_ready), 0);
    step();
    bus.wb_valid = 1;
    bus.wb_reg = 8;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 chk("wb_rdy", 32'(bus.issue_ready), 1);
`else
    #1 chk("wb_rdy", 32'(bus.issue_ready), 0);
`endif
    step();
    bus.wb_valid = 0;
    bus.wb_reg = 0;
    chk("wb_busy", bus.busy_mask, 0);
    chk("wb_infl", 32'(bus.inflight), 0);
    #1 chk("dep_rdy", 32'(bus.issue_ready), 1);
    step();
    idle();
    bus.issue_valid = 1;
    bus.issue_use_rs = 1;
    bus.issue_rs = 0;
    #1 chk("r0_rdy", 32'(bus.issue_ready), 1);
    step();
    idle();
    chk("r0_busy", bus.busy_mask, 0);
    chk("r0_infl", 32'(bus.inflight), 0);
    iss(5);
    iss(6);
    iss(7);
    iss(9);
    chk("full_infl", 32'(bus.inflight), 4);
    chk("full_busy", bus.busy_mask, 32'h2E0);
    bus.issue_valid = 1;
    bus.issue_wreg = 10;
    #1 chk("full_rdy", 32'(bus.issue_ready), 0);
    bus.issue_wreg = 0;
    #1 chk("nowr_rdy", 32'(bus.issue_ready), 1);
    bus.issue_wreg = 10;
    bus.wb_valid = 1;
    bus.wb_reg = 5;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 chk("fwb_rdy", 32'(bus.issue_ready), 1);
    step();
    idle();
    chk("fwb_busy", bus.busy_mask, 32'h6C0);
    chk("fwb_infl", 32'(bus.inflight), 4);
`else
    #1 chk("fwb_rdy", 32'(bus.issue_ready), 0);
    step();
    bus.wb_valid = 0;
    bus.wb_reg = 0;
    chk("fwb_infl", 32'(bus.inflight), 3);
    #1 chk("f10_rdy", 32'(bus.issue_ready), 1);
    step();
    idle();
    chk("f10_busy", bus.busy_mask, 32'h6C0);
    chk("f10_infl", 32'(bus.inflight), 4);
`endif
    do_reset();
    iss(12);
    chk("b12_busy", bus.busy_mask, 32'h1000);
    bus.issue_valid = 1;
    bus.issue_wreg = 13;
    bus.wb_valid = 1;
    bus.wb_reg = 12;
    #1 chk("swap_rdy", 32'(bus.issue_ready), 1);
    step();
    idle();
    chk("swap_busy", bus.busy_mask, 32'h2000);
    chk("swap_infl", 32'(bus.inflight), 1);
    do_reset();
    iss(1);
    iss(2);
    iss(3);
    chk("pre_fl_infl", 32'(bus.inflight), 3);
    bus.flush = 1;
    bus.issue_valid = 1;
    bus.issue_wreg = 4;
    #1 chk("fl_rdy", 32'(bus.issue_ready), 0);
    step();
    idle();
    chk("fl_busy", bus.busy_mask, 0);
    chk("fl_infl", 32'(bus.inflight), 0);
    bus.wb_valid = 1;
    bus.wb_reg = 20;
    step();
    idle();
    chk("err_set", 32'(bus.wb_err), 1);
    chk("err_busy", bus.busy_mask, 0);
    bus.flush = 1;
    step();
    idle();
    chk("err_flush", 32'(bus.wb_err), 1);
    bus.wb_valid = 1;
    bus.wb_reg = 0;
    step();
    idle();
    chk("wb0_infl", 32'(bus.inflight), 0);
    do_reset();
    chk("err_rst", 32'(bus.wb_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-stage hazard controller for the pipelined MIPS core. Tracks which GPRs have an in-flight write, as selected by the destination-register decoder (0 = no write).
- Stalls issue on RAW and WAW hazards and releases registers on writeback.
- Sits between decode (rs/rt/dest fields) and the register-file write port.

Parameters:
- MAX_INFLIGHT, 4, max outstanding writing instructions; range 1..31.
- CNT_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it; fire = valid & ready
- issue_rs  in  5  source register rs
- issue_rt  in  5  source register rt
- issue_use_rs  in  1  instruction reads rs
- issue_use_rt  in  1  instruction reads rt
- issue_wreg  in  5  destination register; 0 = no write
- wb_valid  in  1  writeback retires a register write this cycle
- wb_reg  in  5  register being written back
- flush  in  1  kill all in-flight state (branch/exception)
- busy_mask  out  32  registered busy bit per GPR; bit 0 always 0
- inflight  out  CNT_W  number of pending writes
- wb_err  out  1  sticky: writeback to a non-busy, nonzero register

Behaviour:
- Reset (sync, has priority over everything): busy_mask=0, inflight=0, wb_err=0.
- issue_ready is combinational and is 1 when all of the following hold:
  - no RAW hazard on rs: not (issue_use_rs and rs!=0 and busy[rs]);
  - no RAW hazard on rt: not (issue_use_rt and rt!=0 and busy[rt]);
  - no WAW hazard: not (issue_wreg!=0 and busy[issue_wreg]);
  - not full: not (issue_wreg!=0 and inflight==MAX_INFLIGHT).
  - Non-writing instructions ignore the full check.
- issue_ready does not depend on issue_valid, so it may be high while idle.
- Issue fire with issue_wreg!=0: busy[issue_wreg] is set at the next edge and inflight increments. A fire with issue_wreg==0 changes no state.
- wb_valid with wb_reg!=0 and busy[wb_reg]: the bit clears at the next edge and inflight decrements.
- wb_valid with wb_reg==0: ignored.
- wb_valid with wb_reg!=0 and busy[wb_reg]==0: no state change; wb_err is set and held until reset.
- Same cycle, issue fire and valid wb:
  - Both updates apply.
  - The net inflight change is 0.
  - Different registers: one bit sets, the other clears.
  - The same register cannot fire in the same cycle without the bypass option, because WAW holds issue_ready low.
- flush (priority below reset): clears busy_mask and inflight at the next edge.
  - An issue or wb in the flush cycle is discarded, and issue_ready is forced 0 during flush.
  - wb_err is not cleared.
  - A wb arriving after a flush for a flushed register raises wb_err; the pipeline must squash those writebacks.
- Latency:
  - Hazard release: busy clears at the edge after wb_valid, so a dependent issue is accepted one cycle after writeback (no bypass).
  - Issue-to-busy: 1 cycle, and busy_mask reflects it in that same cycle.
- inflight never wraps. Decrement at 0 and increment at MAX_INFLIGHT are impossible by construction; a simulation assertion checks both.
- bit 0 of busy_mask is tied 0 and never written.

Optional Feature:
- Macro SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - The hazard check uses busy & ~wb_clear_vec, so an instruction waiting on wb_reg is accepted in the same cycle as its writeback. This assumes the register file writes first-half/reads-second-half, or a forwarding path exists.
  - The full check uses inflight minus the same-cycle wb.
  - Same-register issue+wb is allowed: set wins, and the bit stays busy.
- Undefined: the 1-cycle release latency above applies.

Decomposition:
- Shared ISA.v package/header: REG_W=5, NUM_GPR=32, REG_ZERO=0, REG_RA=31, and macros to extract rs/rt fields.
- Optional sub-module scoreboard_hazard_check: purely combinational; takes busy vector, rs/rt/wreg/use flags and wb clear vector; returns ready.
- Busy-vector and counter state stays in reg_scoreboard.

Test Plan:
- Reset, then issue wreg=8 → busy_mask=0x100 and inflight=1 next cycle. Issue use_rs, rs=8 → ready=0. wb_reg=8 → busy clears; the dependent instruction is accepted one cycle later (same cycle with bypass).
- Issue wreg=0 with rs=0 and use_rs while busy_mask=0 → ready=1; busy_mask and inflight unchanged.
- Issue wreg=5,6,7,9 back to back (MAX_INFLIGHT=4) → inflight=4. A fifth issue wreg=10 → ready=0. A non-writing instruction (wreg=0) → ready=1. wb_reg=5 → issue of 10 accepted next cycle.
- busy[12]=1, same cycle issue wreg=13 plus wb_reg=12 → busy_mask=0x2000 and inflight unchanged.
- 3 in flight, assert flush with issue_valid and wreg=4 → busy_mask=0, inflight=0, reg 4 not busy, ready=0 during flush.
- wb_reg=20 while not busy → wb_err=1, stays 1 after flush, cleared only by reset.
